// File: rtl/wb_scoreboard.sv
// Write-back checker: compares each accepted register-file write, in order,
// against a preloaded queue of expected writes and reports pass/fail/timeout.
module wb_scoreboard #(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exp_wr_en,
  input  logic [REG_ADDR_LEN-1:0] exp_dest,
  input  logic [WORD_LEN-1:0]     exp_data,
  input  logic                    start,
  input  logic                    wb_en,
  input  logic [REG_ADDR_LEN-1:0] wb_dest,
  input  logic [WORD_LEN-1:0]     wb_data,
  output logic                    exp_full,
  output logic [15:0]             match_cnt,
  output logic [15:0]             mismatch_cnt,
  output logic [REG_ADDR_LEN-1:0] fail_dest,
  output logic [WORD_LEN-1:0]     fail_data,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = REG_ADDR_LEN + WORD_LEN;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, RUN, PASS, FAIL} state_t;

  state_t                  state;
  logic [EW-1:0]           mem [DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;
  logic [TW-1:0]           idle_cnt;
  logic                    empty, push, accept, is_match, last;
  logic [REG_ADDR_LEN-1:0] head_dest;
  logic [WORD_LEN-1:0]     head_data;

  // The extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty    = (wr_ptr == rd_ptr);
  assign exp_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign {head_dest, head_data} = mem[rd_ptr[AW-1:0]];

  assign push     = (state == LOAD) && exp_wr_en && !exp_full;
  assign accept   = (state == RUN) && wb_en && (wb_dest != '0);
  assign is_match = (wb_dest == head_dest) && (wb_data == head_data);
  assign last     = ((rd_ptr + (AW+1)'(1)) == wr_ptr);

  // NOTE: the queue storage has no reset; contents are meaningless until pushed
  // and the pointers alone define validity, so resetting the array buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {exp_dest, exp_data};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      idle_cnt     <= '0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      fail_dest    <= '0;
      fail_data    <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
          if (start) begin
            idle_cnt <= '0;
            if (empty && !push) begin
              state <= PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            rd_ptr   <= rd_ptr + (AW+1)'(1);
            idle_cnt <= '0;
            if (is_match) begin
              if (match_cnt != 16'hFFFF) match_cnt <= match_cnt + 16'd1;
            end else begin
              if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
              if (mismatch_cnt == 16'd0) begin
                fail_dest <= wb_dest;
                fail_data <= wb_data;
              end
            end
            if (last) begin
              done <= 1'b1;
              if (is_match && (mismatch_cnt == 16'd0)) begin
                state <= PASS;
                pass  <= 1'b1;
              end else begin
                state <= FAIL;
              end
            end
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            idle_cnt <= idle_cnt + TW'(1);
            state    <= FAIL;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        default: ; // PASS and FAIL hold everything until reset
      endcase
    end
  end

endmodule
